// File: rtl/mig_rr_merge_pkg.sv
// mig_rr_merge_pkg: MIG native bus packing helpers and merge FSM state shared by the merge block
package mig_rr_merge_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/mig_rr_merge_rr_arbiter.sv
// rr_arbiter: combinational round-robin or fixed-priority pick among N requests
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = 1,
  parameter int MODE = 0
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  // both scans let the winning position overwrite idx last
  always_comb begin
    idx = '0;
    if (MODE != 0) begin
      for (int k = 0; k < N; k++) if (req[k]) idx = IW'(k);
    end else begin
      for (int k = N - 1; k >= 0; k--) if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
    end
  end
  assign any = |req;
  assign onehot = any ? N'(1) << idx : '0;
endmodule

// File: rtl/mig_rr_merge.sv
// mig_rr_merge: N-master to one-slave MIG bus merge with locked grants and an L2 invalidate sequencer
module mig_rr_merge
  import mig_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256,
  parameter int ARB_MODE = 0,
  localparam int REQ_W = req_w(ADDR_W, DATA_W),
  localparam int RESP_W = resp_w(DATA_W),
  localparam int GW = $clog2(N_MASTERS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp,
  input  logic                        inv_in,
  output logic                        inv_out,
  output logic [GW-1:0]               grant,
  output logic                        busy
);
  state_t state;
  logic [GW-1:0] ptr, sel, cur;
  logic [N_MASTERS-1:0] m_valid, onehot, ready_vec;
  logic any, bubble, inv_pending, launch, done, fire;
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
    assign m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
    assign m_resp[i*RESP_W +: RESP_W] = {s_resp[RESP_W-1:1], ready_vec[i]};
  end
  rr_arbiter #(.N(N_MASTERS), .IW(GW), .MODE(ARB_MODE)) u_arb (
    .req(m_valid), .ptr(ptr), .onehot(onehot), .idx(sel), .any(any)
  );
  assign busy = state == BUSY;
  // grants stay blocked through the bubble, the pending invalidate and its pulse
  assign launch = rst && !busy && !bubble && !inv_pending && !inv_out && any;
  assign cur = busy ? grant : sel;
  assign done = (busy || launch) && s_resp[0];
  assign fire = inv_pending && (!busy || done);
  assign s_req = busy || launch ? m_req[int'(cur)*REQ_W +: REQ_W] : '0;
  assign ready_vec = !done ? '0 : busy ? N_MASTERS'(1) << grant : onehot;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
      bubble <= 1'b0;
      inv_pending <= 1'b0;
      inv_out <= 1'b0;
    end else begin
      state <= launch && !s_resp[0] ? BUSY : done ? IDLE : state;
      grant <= launch ? sel : grant;
      ptr <= done ? (cur == GW'(N_MASTERS - 1) ? '0 : cur + 1'b1) : ptr;
      bubble <= done;
      inv_out <= fire;
      inv_pending <= !fire && (inv_pending || (inv_in && !inv_out));
    end
  end
endmodule
